ahb_slave_interface: RTL and testbench

AHB_SLAVE_INTERFACE -- requirements
Module: ahb_slave_interface

---
 rtl/ahb_slave_interface.sv | 128 ++++++++++++
 tb/tb_ahb_slave_interface.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_interface.sv
// AHB slave front end: address decode, transfer legality check, address/data pipeline and a
// two-cycle ERROR responder.
//
// Ports
//   Hclk, Hreset           clock, synchronous active-high reset
//   Hwrite, Hreadyin       AHB direction and bus-ready
//   Htrans, Hsize          AHB transfer type and size
//   Haddr, Hwdata          AHB address (address phase) and write data (data phase)
//   valid                  legal, mapped, active transfer accepted this cycle (combinational)
//   Haddr1/2, Hwdata1/2    address / write data delayed by 1 and 2 accepted cycles
//   Hwritereg              Hwrite delayed by 1 accepted cycle
//   tempselx               one-hot peripheral select decoded from Haddr (combinational)
//   Hresp, Hreadyout_err   response and ready contribution from the error responder
module ahb_slave_interface (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hsize,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [1:0]  Hresp,
    output logic        Hreadyout_err
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StErr1 = 2'b01,
        StErr2 = 2'b10
    } state_e;

    state_e      state_q;
    logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
    logic        hwrite_q;
    logic        active, size_ok, illegal;

    // Each peripheral owns a 64 MiB window starting at 0x8000_0000.
    always_comb begin
        tempselx = 3'b000;
        unique case (Haddr[31:26])
            6'b100000: tempselx = 3'b001;
            6'b100001: tempselx = 3'b010;
            6'b100010: tempselx = 3'b100;
            default:   tempselx = 3'b000;
        endcase
    end

    // NONSEQ and SEQ both have Htrans[1] set; IDLE and BUSY never count.
    assign active = Hreadyin && Htrans[1];

    always_comb begin
        size_ok = 1'b0;
        case (Hsize)
            3'd0:    size_ok = 1'b1;
            3'd1:    size_ok = ~Haddr[0];
            3'd2:    size_ok = (Haddr[1:0] == 2'b00);
            default: size_ok = 1'b0;
        endcase
    end

    assign illegal = active && ((tempselx == 3'b000) || !size_ok);
    assign valid   = (state_q == StIdle) && active && !illegal;

    // Pipeline advances on every accepted cycle, independent of valid or error state.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            haddr1_q  <= '0;
            haddr2_q  <= '0;
            hwdata1_q <= '0;
            hwdata2_q <= '0;
            hwrite_q  <= 1'b0;
        end else if (Hreadyin) begin
            haddr1_q  <= Haddr;
            haddr2_q  <= haddr1_q;
            hwdata1_q <= Hwdata;
            hwdata2_q <= hwdata1_q;
            hwrite_q  <= Hwrite;
        end
    end

    // Detection only matters in StIdle; transfers seen during the error response are dropped.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle:  state_q <= illegal ? StErr1 : StIdle;
                StErr1:  state_q <= StErr2;
                StErr2:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        Hresp         = 2'b00;
        Hreadyout_err = 1'b1;
        case (state_q)
            StErr1: begin
                Hresp         = 2'b01;
                Hreadyout_err = 1'b0;
            end
            StErr2: begin
                Hresp         = 2'b01;
                Hreadyout_err = 1'b1;
            end
            default: begin
                Hresp         = 2'b00;
                Hreadyout_err = 1'b1;
            end
        endcase
    end

    assign Haddr1    = haddr1_q;
    assign Haddr2    = haddr2_q;
    assign Hwdata1   = hwdata1_q;
    assign Hwdata2   = hwdata2_q;
    assign Hwritereg = hwrite_q;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Self-checking bench for ahb_slave_interface: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_ahb_slave_interface;

    logic        Hclk = 1'b0;
    logic        Hreset, Hwrite, Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr, Hwdata;
    logic        valid, Hwritereg, Hreadyout_err;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
    logic [2:0]  tempselx;
    logic [1:0]  Hresp;

    ahb_slave_interface dut (
        .Hclk          (Hclk),
        .Hreset        (Hreset),
        .Hwrite        (Hwrite),
        .Hreadyin      (Hreadyin),
        .Htrans        (Htrans),
        .Hsize         (Hsize),
        .Haddr         (Haddr),
        .Hwdata        (Hwdata),
        .valid         (valid),
        .Haddr1        (Haddr1),
        .Haddr2        (Haddr2),
        .Hwdata1       (Hwdata1),
        .Hwdata2       (Hwdata2),
        .Hwritereg     (Hwritereg),
        .tempselx      (tempselx),
        .Hresp         (Hresp),
        .Hreadyout_err (Hreadyout_err)
    );

    always #5 Hclk = ~Hclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: history of accepted beats and remaining ERROR cycles.
    logic [31:0] m_addr_hist [2];
    logic [31:0] m_data_hist [2];
    logic        m_wr;
    int          m_err_left;   // 2: first ERROR cycle (not ready), 1: second, 0: none

    // Observations captured mid-cycle for explicit scenario checks.
    logic        obs_valid, obs_rdy;
    logic [2:0]  obs_sel;
    logic [1:0]  obs_resp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] region_of(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
        if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
        if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit is_legal(input logic [2:0] sz, input logic [31:0] a);
        if (region_of(a) == 3'b000) return 1'b0;
        if (sz == 3'd0) return 1'b1;
        if (sz == 3'd1) return (a % 2) == 0;
        if (sz == 3'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    // One bus cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic step(input logic rst, input logic rdy, input logic [1:0] tr,
                        input logic [2:0] sz, input logic [31:0] ad, input logic wr,
                        input logic [31:0] wd, input bit chk);
        bit act, exp_valid;
        Hreset = rst; Hreadyin = rdy; Htrans = tr; Hsize = sz; Haddr = ad;
        Hwrite = wr; Hwdata = wd;
        @(negedge Hclk);
        act       = rdy && (tr == 2'b10 || tr == 2'b11);
        exp_valid = (m_err_left == 0) && act && is_legal(sz, ad);
        obs_valid = valid; obs_sel = tempselx; obs_resp = Hresp; obs_rdy = Hreadyout_err;
        if (chk) begin
            check("valid", {31'd0, valid}, {31'd0, exp_valid});
            check("tempselx", {29'd0, tempselx}, {29'd0, region_of(ad)});
            check("Hresp", {30'd0, Hresp}, (m_err_left != 0) ? 32'd1 : 32'd0);
            check("Hreadyout_err", {31'd0, Hreadyout_err}, {31'd0, m_err_left != 2});
            check("Haddr1", Haddr1, m_addr_hist[0]);
            check("Haddr2", Haddr2, m_addr_hist[1]);
            check("Hwdata1", Hwdata1, m_data_hist[0]);
            check("Hwdata2", Hwdata2, m_data_hist[1]);
            check("Hwritereg", {31'd0, Hwritereg}, {31'd0, m_wr});
        end
        @(posedge Hclk);
        if (rst) begin
            m_addr_hist = '{32'd0, 32'd0};
            m_data_hist = '{32'd0, 32'd0};
            m_wr        = 1'b0;
            m_err_left  = 0;
        end else begin
            if (rdy) begin
                m_addr_hist[1] = m_addr_hist[0]; m_addr_hist[0] = ad;
                m_data_hist[1] = m_data_hist[0]; m_data_hist[0] = wd;
                m_wr = wr;
            end
            if (m_err_left > 0) m_err_left--;
            else if (act && !is_legal(sz, ad)) m_err_left = 2;
        end
        #1;
    endtask

    task automatic idle_cycle(input logic [31:0] wd);
        step(1'b0, 1'b1, 2'b00, 3'd0, 32'h0000_0000, 1'b0, wd, 1'b1);
    endtask

    logic [31:0] hold_a1, hold_a2, hold_d1, hold_d2;

    initial begin
        m_addr_hist = '{32'd0, 32'd0};
        m_data_hist = '{32'd0, 32'd0};
        m_wr = 1'b0; m_err_left = 0;
        #1;
        // Outputs are unknown until the first reset edge.
        step(1'b1, 1'b0, 2'b00, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 2'b00, 3'd0, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1);
        check("reset_Haddr1", Haddr1, 32'd0);
        check("reset_Hresp", {30'd0, Hresp}, 32'd0);
        check("reset_ready", {31'd0, Hreadyout_err}, 32'd1);

        // Legal word write
        step(1'b0, 1'b1, 2'b10, 3'd2, 32'h8000_0010, 1'b1, 32'h0, 1'b1);
        check("legal_valid", {31'd0, obs_valid}, 32'd1);
        check("legal_sel", {29'd0, obs_sel}, 32'd1);
        check("legal_Haddr1", Haddr1, 32'h8000_0010);
        check("legal_Hwritereg", {31'd0, Hwritereg}, 32'd1);
        idle_cycle(32'hDEAD_BEEF);
        idle_cycle(32'h0);
        check("legal_Hwdata2", Hwdata2, 32'hDEAD_BEEF);

        // Stall holds the pipeline
        hold_a1 = Haddr1; hold_a2 = Haddr2; hold_d1 = Hwdata1; hold_d2 = Hwdata2;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 2'b10, 3'd0, 32'h8800_0000 + i, 1'b0, 32'hA5A5_0000 + i, 1'b1);
        check("stall_Haddr1", Haddr1, hold_a1);
        check("stall_Haddr2", Haddr2, hold_a2);
        check("stall_Hwdata1", Hwdata1, hold_d1);
        check("stall_Hwdata2", Hwdata2, hold_d2);
        step(1'b0, 1'b1, 2'b10, 3'd0, 32'h8800_0040, 1'b0, 32'h5555_AAAA, 1'b1);
        check("unstall_Haddr1", Haddr1, 32'h8800_0040);
        check("unstall_Haddr2", Haddr2, hold_a1);

        // Unmapped address -> two-cycle ERROR
        step(1'b0, 1'b1, 2'b10, 3'd2, 32'h9000_0000, 1'b0, 32'h0, 1'b1);
        check("unmapped_valid", {31'd0, obs_valid}, 32'd0);
        check("unmapped_sel", {29'd0, obs_sel}, 32'd0);
        idle_cycle(32'h0);
        check("err1_resp", {30'd0, obs_resp}, 32'd1);
        check("err1_ready", {31'd0, obs_rdy}, 32'd0);
        idle_cycle(32'h0);
        check("err2_resp", {30'd0, obs_resp}, 32'd1);
        check("err2_ready", {31'd0, obs_rdy}, 32'd1);
        idle_cycle(32'h0);
        check("post_err_resp", {30'd0, obs_resp}, 32'd0);

        // Misaligned word, then byte to the same address
        step(1'b0, 1'b1, 2'b11, 3'd2, 32'h8400_0002, 1'b1, 32'h0, 1'b1);
        check("misalign_valid", {31'd0, obs_valid}, 32'd0);
        idle_cycle(32'h0);
        check("misalign_err1", {30'd0, obs_resp}, 32'd1);
        idle_cycle(32'h0);
        step(1'b0, 1'b1, 2'b10, 3'd0, 32'h8400_0002, 1'b1, 32'h0, 1'b1);
        check("byte_valid", {31'd0, obs_valid}, 32'd1);
        check("byte_sel", {29'd0, obs_sel}, 32'd2);

        // BUSY is never active
        step(1'b0, 1'b1, 2'b01, 3'd2, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
        check("busy_valid", {31'd0, obs_valid}, 32'd0);
        idle_cycle(32'h0);
        check("busy_no_err", {30'd0, obs_resp}, 32'd0);

        // Legal transfer during ERR1 is dropped; illegal one during ERR2 raises nothing
        step(1'b0, 1'b1, 2'b10, 3'd5, 32'h8000_0000, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 2'b10, 3'd2, 32'h8000_0100, 1'b0, 32'h0, 1'b1);
        check("suppress_valid", {31'd0, obs_valid}, 32'd0);
        step(1'b0, 1'b1, 2'b10, 3'd2, 32'hF000_0000, 1'b0, 32'h0, 1'b1);
        idle_cycle(32'h0);
        check("suppress_no_err", {30'd0, obs_resp}, 32'd0);

        // Reset while in ERR1
        step(1'b0, 1'b1, 2'b10, 3'd1, 32'h8000_0001, 1'b1, 32'h1111_1111, 1'b1);
        step(1'b1, 1'b1, 2'b00, 3'd0, 32'h8000_0000, 1'b1, 32'h2222_2222, 1'b1);
        check("rst_err_resp", {30'd0, Hresp}, 32'd0);
        check("rst_err_ready", {31'd0, Hreadyout_err}, 32'd1);
        check("rst_err_Haddr1", Haddr1, 32'd0);
        check("rst_err_Hwdata2", Hwdata2, 32'd0);
        check("rst_err_Hwritereg", {31'd0, Hwritereg}, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            logic [31:0] base;
            case ($urandom_range(0, 4))
                0: base = 32'h8000_0000;
                1: base = 32'h8400_0000;
                2: base = 32'h8800_0000;
                3: base = 32'h8C00_0000;
                default: base = $urandom;
            endcase
            a = base + ($urandom_range(0, 3) == 0 ? 32'h03FF_FFFC + $urandom_range(0, 7)
                                                  : {24'd0, 8'($urandom)});
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom), 3'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 2)),
                 a, 1'($urandom), $urandom, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
